// File: rtl/aes_dec_arbiter.sv
// aes_dec_arbiter: two-channel round-robin sequencer sharing one AES decipher core.
// Optional per-channel completion counters are enabled by defining AES_DEC_ARB_STATS_EN.
module aes_dec_arbiter #(
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [127:0]      req0_block,
  input  logic              req0_keylen,
  output logic              resp0_valid,
  input  logic              resp0_ready,
  output logic [127:0]      resp0_block,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [127:0]      req1_block,
  input  logic              req1_keylen,
  output logic              resp1_valid,
  input  logic              resp1_ready,
  output logic [127:0]      resp1_block,
  output logic              core_next,
  output logic              core_keylen,
  output logic [127:0]      core_block,
  input  logic [3:0]        core_round,
  input  logic              core_ready,
  input  logic [127:0]      core_new_block,
  output logic [4:0]        rk_addr,
  input  logic [127:0]      rk_data,
  output logic [127:0]      core_round_key
`ifdef AES_DEC_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] done_cnt0,
  output logic [STAT_W-1:0] done_cnt1
`endif
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_START    = 2'd1;
  localparam logic [1:0] ST_WAIT_ACK = 2'd2;
  localparam logic [1:0] ST_BUSY     = 2'd3;

  if (STAT_W < 1) begin : g_bad_stat_w
    $error("STAT_W must be at least 1");
  end

  logic [1:0]   state_r;
  logic [1:0]   state_nxt_s;
  logic         cur_ch_r;
  logic         prio_r;
  logic         core_next_r;
  logic         core_keylen_r;
  logic [127:0] core_block_r;
  logic         resp0_valid_r;
  logic         resp1_valid_r;
  logic [127:0] resp0_block_r;
  logic [127:0] resp1_block_r;
  logic         elig0_s;
  logic         elig1_s;
  logic         grant0_s;
  logic         grant1_s;
  logic         accept_s;
  logic         capture_s;

  assign elig0_s   = req0_valid & ~resp0_valid_r;
  assign elig1_s   = req1_valid & ~resp1_valid_r;
  assign accept_s  = grant0_s | grant1_s;
  assign capture_s = (state_r == ST_BUSY) & core_ready;

  // Grant selection; prio breaks the tie only when both channels are eligible.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (state_r == ST_IDLE) begin
      if (elig0_s && elig1_s) begin
        grant0_s = ~prio_r;
        grant1_s = prio_r;
      end else begin
        grant0_s = elig0_s;
        grant1_s = elig1_s;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Job sequencing state machine next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nxt_s = ST_START;
        else          state_nxt_s = ST_IDLE;
      end
      ST_START: state_nxt_s = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (!core_ready) state_nxt_s = ST_BUSY;
        else             state_nxt_s = ST_WAIT_ACK;
      end
      ST_BUSY: begin
        if (core_ready) state_nxt_s = ST_IDLE;
        else            state_nxt_s = ST_BUSY;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state, job latch, start pulse and round-robin pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_IDLE;
      cur_ch_r      <= 1'b0;
      prio_r        <= 1'b0;
      core_next_r   <= 1'b0;
      core_keylen_r <= 1'b0;
      core_block_r  <= 128'd0;
    end else begin
      state_r     <= state_nxt_s;
      core_next_r <= accept_s;
      if (accept_s) begin
        cur_ch_r      <= grant1_s;
        core_block_r  <= grant1_s ? req1_block : req0_block;
        core_keylen_r <= grant1_s ? req1_keylen : req0_keylen;
      end
      if (capture_s) begin
        prio_r <= ~cur_ch_r;
      end
    end
  end

  // Response buffers: filled on capture, emptied after the consumer handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp0_valid_r <= 1'b0;
      resp1_valid_r <= 1'b0;
      resp0_block_r <= 128'd0;
      resp1_block_r <= 128'd0;
    end else begin
      if (capture_s && !cur_ch_r) begin
        resp0_valid_r <= 1'b1;
        resp0_block_r <= core_new_block;
      end else if (resp0_valid_r && resp0_ready) begin
        resp0_valid_r <= 1'b0;
      end
      if (capture_s && cur_ch_r) begin
        resp1_valid_r <= 1'b1;
        resp1_block_r <= core_new_block;
      end else if (resp1_valid_r && resp1_ready) begin
        resp1_valid_r <= 1'b0;
      end
    end
  end

`ifdef AES_DEC_ARB_STATS_EN
  logic [STAT_W-1:0] done_cnt0_r;
  logic [STAT_W-1:0] done_cnt1_r;

  // Completion counters, wrapping naturally at STAT_W bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_cnt0_r <= {STAT_W{1'b0}};
      done_cnt1_r <= {STAT_W{1'b0}};
    end else begin
      if (capture_s && !cur_ch_r) done_cnt0_r <= done_cnt0_r + {{(STAT_W-1){1'b0}}, 1'b1};
      if (capture_s && cur_ch_r)  done_cnt1_r <= done_cnt1_r + {{(STAT_W-1){1'b0}}, 1'b1};
    end
  end

  assign done_cnt0 = done_cnt0_r;
  assign done_cnt1 = done_cnt1_r;
`else
`endif

  assign req0_ready     = grant0_s;
  assign req1_ready     = grant1_s;
  assign resp0_valid    = resp0_valid_r;
  assign resp1_valid    = resp1_valid_r;
  assign resp0_block    = resp0_block_r;
  assign resp1_block    = resp1_block_r;
  assign core_next      = core_next_r;
  assign core_keylen    = core_keylen_r;
  assign core_block     = core_block_r;
  assign rk_addr        = {cur_ch_r, core_round};
  assign core_round_key = rk_data;

endmodule

// File: tb/tb_aes_dec_arbiter.sv
// Self-checking bench for aes_dec_arbiter: a behavioural core stand-in plus a
// cycle-level model of arbitration, response buffers and job latency.
module tb_aes_dec_arbiter;
  localparam int STAT_W = 2;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         req0_valid, req0_ready, req0_keylen, resp0_valid, resp0_ready;
  logic         req1_valid, req1_ready, req1_keylen, resp1_valid, resp1_ready;
  logic [127:0] req0_block, resp0_block, req1_block, resp1_block;
  logic         core_next, core_keylen, core_ready;
  logic [127:0] core_block, core_new_block, rk_data, core_round_key;
  logic [3:0]   core_round;
  logic [4:0]   rk_addr;
`ifdef AES_DEC_ARB_STATS_EN
  logic [STAT_W-1:0] done_cnt0, done_cnt1;
`endif

  always #5 clk = ~clk;

  aes_dec_arbiter #(.STAT_W(STAT_W)) dut (
`ifdef AES_DEC_ARB_STATS_EN
    .done_cnt0(done_cnt0), .done_cnt1(done_cnt1),
`endif
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_block(req0_block), .req0_keylen(req0_keylen),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_block(resp0_block),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_block(req1_block), .req1_keylen(req1_keylen),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_block(resp1_block),
    .core_next(core_next), .core_keylen(core_keylen), .core_block(core_block),
    .core_round(core_round), .core_ready(core_ready), .core_new_block(core_new_block),
    .rk_addr(rk_addr), .rk_data(rk_data), .core_round_key(core_round_key)
  );

  // Shared round-key store with combinational read.
  logic [127:0] rk_mem [0:31];
  assign rk_data = rk_mem[rk_addr];

  // Core stand-in: after core_next it drops ready, walks rounds nr..0 folding in
  // the round key presented for each round, then raises ready with the result.
  logic         m_busy;
  logic [127:0] m_acc;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_ready <= 1'b1; core_round <= 4'd0; m_busy <= 1'b0;
      m_acc <= 128'd0; core_new_block <= 128'd0;
    end else if (core_next) begin
      m_busy <= 1'b1; m_acc <= core_block; core_ready <= 1'b0;
      core_round <= core_keylen ? 4'd14 : 4'd10;
    end else if (m_busy) begin
      if (core_round == 4'd0) begin
        core_new_block <= m_acc ^ core_round_key; core_ready <= 1'b1; m_busy <= 1'b0;
      end else begin
        m_acc <= m_acc ^ core_round_key; core_round <= core_round - 4'd1;
      end
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected result of one job: ciphertext folded with every round key of its channel.
  function automatic logic [127:0] ref_plain(input logic [127:0] b, input logic kl, input logic ch);
    logic [127:0] r;
    r = b;
    for (int i = 0; i <= (kl ? 14 : 10); i++) r = r ^ rk_mem[{ch, 4'(i)}];
    return r;
  endfunction

  // Model state
  logic [128:0] rq0[$], rq1[$];
  int           grant_log[$];
  logic         full_m [2];
  logic [127:0] exp_blk [2];
  logic [STAT_W-1:0] cnt_m [2];
  logic         prio_m, inflight, job_ch, job_kl;
  logic [127:0] job_blk, job_exp;
  int           cyc, start_cyc, done_cyc, n_pulse;

  task automatic model_clear();
    full_m[0] = 1'b0; full_m[1] = 1'b0; cnt_m[0] = '0; cnt_m[1] = '0;
    prio_m = 1'b0; inflight = 1'b0;
  endtask

  task automatic present();
    logic [128:0] h;
    req0_valid = (rq0.size() > 0);
    h = (rq0.size() > 0) ? rq0[0] : 129'd0;
    req0_keylen = h[128]; req0_block = h[127:0];
    req1_valid = (rq1.size() > 0);
    h = (rq1.size() > 0) ? rq1[0] : 129'd0;
    req1_keylen = h[128]; req1_block = h[127:0];
  endtask

  // One clock cycle: drive, check against the model, then advance the model.
  task automatic tick();
    logic e0, e1, g0, g1, p0, p1;
    logic [128:0] tmp;
    present();
    #1;
    e0 = req0_valid && !full_m[0];
    e1 = req1_valid && !full_m[1];
    g0 = !inflight && e0 && (!e1 || !prio_m);
    g1 = !inflight && e1 && (!e0 || prio_m);
    chk("req0_ready", req0_ready, g0);
    chk("req1_ready", req1_ready, g1);
    chk("resp0_valid", resp0_valid, full_m[0]);
    chk("resp1_valid", resp1_valid, full_m[1]);
    if (full_m[0]) chk("resp0_block", resp0_block, exp_blk[0]);
    if (full_m[1]) chk("resp1_block", resp1_block, exp_blk[1]);
    chk("core_next", core_next, inflight && (cyc == start_cyc));
    if (core_next) n_pulse++;
    if (inflight) begin
      chk("core_block", core_block, job_blk);
      chk("core_keylen", core_keylen, job_kl);
      chk("rk_addr", rk_addr, {job_ch, core_round});
    end
`ifdef AES_DEC_ARB_STATS_EN
    chk("done_cnt0", done_cnt0, cnt_m[0]);
    chk("done_cnt1", done_cnt1, cnt_m[1]);
`endif
    p0 = full_m[0] && resp0_ready;
    p1 = full_m[1] && resp1_ready;
    if (g0 || g1) begin
      job_ch  = g1;
      job_kl  = g1 ? req1_keylen : req0_keylen;
      job_blk = g1 ? req1_block : req0_block;
      job_exp = ref_plain(job_blk, job_kl, job_ch);
    end
    @(posedge clk);
    cyc++;
    if (g0) tmp = rq0.pop_front();
    if (g1) tmp = rq1.pop_front();
    if (g0 || g1) begin
      inflight = 1'b1; start_cyc = cyc;
      done_cyc = cyc + 3 + (job_kl ? 14 : 10);
      grant_log.push_back(int'(g1));
    end
    if (p0) full_m[0] = 1'b0;
    if (p1) full_m[1] = 1'b0;
    if (inflight && cyc == done_cyc) begin
      full_m[job_ch] = 1'b1; exp_blk[job_ch] = job_exp;
      cnt_m[job_ch] = cnt_m[job_ch] + 1'b1;
      prio_m = ~job_ch; inflight = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic wait_full(input int ch, input int budget);
    for (int i = 0; i < budget && !full_m[ch]; i++) tick();
    chk($sformatf("wait_full%0d", ch), full_m[ch], 1'b1);
  endtask

  task automatic wait_grants(input int n, input int budget);
    for (int i = 0; i < budget && grant_log.size() < n; i++) tick();
    chk("wait_grants", grant_log.size(), n);
  endtask

  task automatic wait_quiet(input int budget);
    logic busy;
    busy = 1'b1;
    for (int i = 0; i < budget && busy; i++) begin
      tick();
      busy = inflight || full_m[0] || full_m[1] || (rq0.size() > 0) || (rq1.size() > 0);
    end
    chk("wait_quiet", busy, 1'b0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_resp0_valid", resp0_valid, 1'b0);
    chk("rst_resp1_valid", resp1_valid, 1'b0);
    chk("rst_req0_ready", req0_ready, 1'b0);
    chk("rst_req1_ready", req1_ready, 1'b0);
    chk("rst_core_next", core_next, 1'b0);
    model_clear();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  initial begin
    int base;
    for (int i = 0; i < 32; i++) rk_mem[i] = {$urandom, $urandom, $urandom, $urandom};
    reset_n = 1'b0; resp0_ready = 1'b0; resp1_ready = 1'b0;
    cyc = 0; start_cyc = -10; done_cyc = -10; n_pulse = 0;
    model_clear();
    present();
    @(negedge clk);
    @(negedge clk);
    chk("rst_core_block", core_block, 128'd0);
    chk("rst_core_keylen", core_keylen, 1'b0);
    chk("rst_rk_addr", rk_addr, 5'd0);
    chk("rst_resp0_block", resp0_block, 128'd0);
    chk("rst_resp1_block", resp1_block, 128'd0);
    chk("rst_resp0_valid", resp0_valid, 1'b0);
    chk("rst_core_next", core_next, 1'b0);
    reset_n = 1'b1;

    // AES-128 style job on channel 0
    base = n_pulse;
    rq0.push_back({1'b0, CT128});
    wait_full(0, 40);
    chk("ch0_grant", grant_log[grant_log.size()-1], 0);
    chk("ch0_pulses", n_pulse - base, 1);
    resp0_ready = 1'b1; tick(); resp0_ready = 1'b0; tick();

    // AES-256 style job on channel 1
    base = n_pulse;
    rq1.push_back({1'b1, CT256});
    wait_full(1, 40);
    chk("ch1_grant", grant_log[grant_log.size()-1], 1);
    chk("ch1_pulses", n_pulse - base, 1);
    resp1_ready = 1'b1; tick(); tick();

    // Both requesting: 0 then 1, then a channel-0 request raised during job 2
    resp0_ready = 1'b1;
    base = grant_log.size();
    rq0.push_back({1'b0, 128'h0123456789abcdef0011223344556677});
    rq1.push_back({1'b1, 128'hfedcba98765432108899aabbccddeeff});
    wait_grants(base + 2, 60);
    rq0.push_back({1'b1, 128'h00000000ffffffff00000000ffffffff});
    wait_grants(base + 3, 60);
    chk("rr_first", grant_log[base], 0);
    chk("rr_second", grant_log[base+1], 1);
    chk("rr_third", grant_log[base+2], 0);
    wait_quiet(60);

    // Full channel-0 buffer blocks channel 0 while channel 1 is served
    resp0_ready = 1'b0;
    rq0.push_back({1'b0, 128'h11111111222222223333333344444444});
    wait_full(0, 40);
    rq0.push_back({1'b0, 128'h55555555666666667777777788888888});
    rq1.push_back({1'b0, 128'h9999999aaaaaaaabbbbbbbbcccccccc0});
    wait_full(1, 40);
    chk("bp_served_ch1", grant_log[grant_log.size()-1], 1);
    chk("bp_ch0_waiting", rq0.size(), 1);
    resp0_ready = 1'b1;
    wait_quiet(60);
    chk("bp_then_ch0", grant_log[grant_log.size()-1], 0);

    // Reset while BUSY, then a fresh job
    rq0.push_back({1'b0, CT128});
    for (int i = 0; i < 20 && !(inflight && cyc >= start_cyc + 4); i++) tick();
    chk("reached_busy", inflight, 1'b1);
    do_reset();
    rq0.push_back({1'b0, CT128});
    wait_full(0, 40);
    wait_quiet(20);

    // Five channel-0 jobs from reset
    do_reset();
    base = grant_log.size();
    for (int j = 0; j < 5; j++) begin
      rq0.push_back({1'b0, {$urandom, $urandom, $urandom, $urandom}});
      wait_quiet(60);
    end
    chk("five_jobs", grant_log.size() - base, 5);
`ifdef AES_DEC_ARB_STATS_EN
    chk("stats_cnt0", done_cnt0, 2'd1);
    chk("stats_cnt1", done_cnt1, 2'd0);
`endif

    // Randomised traffic and consumer back-pressure
    for (int i = 0; i < 400; i++) begin
      if (rq0.size() < 2 && $urandom_range(0, 3) == 0)
        rq0.push_back({1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom}});
      if (rq1.size() < 2 && $urandom_range(0, 3) == 0)
        rq1.push_back({1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom}});
      resp0_ready = 1'($urandom_range(0, 1));
      resp1_ready = 1'($urandom_range(0, 1));
      tick();
    end
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    wait_quiet(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
